cpr_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the shared 16-bit cpr storage block (ports clk/re/we/wd1/wd2/rd).
- Accepts write or read transactions from two independent clients.
- Drives one-cycle cpr write/read strobes and captures read data.
- Returns a done pulse to the granted client.
- Sits between client logic and the single cpr instance, so cpr is never driven by two masters.

---
 rtl/cpr_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/cpr_arbiter.sv
// cpr_arbiter: two-client round-robin arbiter/sequencer for the shared cpr storage block
//   clk, rst_n             : clock, async active-low reset
//   req*/op*/wdata*        : client requests (op 0 = write, 1 = read), write data {wd1,wd2}
//   gnt*/done*/rdata       : grant, one-cycle completion pulse, captured read data
//   busy/xfer_cnt          : FSM not idle, wrapping count of completed transactions
//   cpr_we/cpr_re/cpr_wd1/cpr_wd2/cpr_rd : cpr strobes, write words and read data
module cpr_arbiter #(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            op0,
  input  logic [2*DW-1:0] wdata0,
  input  logic            req1,
  input  logic            op1,
  input  logic [2*DW-1:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic [CW-1:0]   xfer_cnt,
  output logic            cpr_we,
  output logic            cpr_re,
  output logic [DW-1:0]   cpr_wd1,
  output logic [DW-1:0]   cpr_wd2,
  input  logic [DW-1:0]   cpr_rd
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic ptr, who, op_q, win1, op_sel, start;
  logic [2*DW-1:0] wd_sel;
  // ptr holds the last-served client; on a tie the other one wins
  assign win1   = req1 & (~req0 | ~ptr);
  assign op_sel = win1 ? op1 : op0;
  assign wd_sel = win1 ? wdata1 : wdata0;
  assign start  = (state == IDLE) & (req0 | req1);
  assign busy   = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? EXEC : IDLE) :
               state == EXEC ? (op_q ? WAIT : DONE) :
               state == WAIT ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b1;
      who      <= 1'b0;
      op_q     <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata    <= '0;
      xfer_cnt <= '0;
      cpr_we   <= 1'b0;
      cpr_re   <= 1'b0;
      cpr_wd1  <= '0;
      cpr_wd2  <= '0;
    end else begin
      if (start) begin
        who    <= win1;
        op_q   <= op_sel;
        gnt0   <= ~win1;
        gnt1   <= win1;
        cpr_we <= ~op_sel;
        cpr_re <= op_sel;
        if (!op_sel) begin
          cpr_wd1 <= wd_sel[2*DW-1:DW];
          cpr_wd2 <= wd_sel[DW-1:0];
        end
      end
      if (state == EXEC) begin
        cpr_we <= 1'b0;
        cpr_re <= 1'b0;
        done0  <= ~op_q & ~who;
        done1  <= ~op_q & who;
      end
      if (state == WAIT) begin
        rdata <= cpr_rd;
        done0 <= ~who;
        done1 <= who;
      end
      if (state == DONE) begin
        done0    <= 1'b0;
        done1    <= 1'b0;
        gnt0     <= 1'b0;
        gnt1     <= 1'b0;
        xfer_cnt <= xfer_cnt + 1'b1;
        ptr      <= who;
      end
    end
  end
endmodule
